// File: rtl/encoder_8to3_seq_pkg.sv
// rtl/encoder_8to3_seq_pkg.sv - shared types and widths for the sequential 8-to-3 encoder
//
// Purpose : FSM state typedef and the fixed vector/code widths used by the
//           encoder, its priority-encoder helper and its bus interface.
// Ports   : none (package).
package encoder_pkg;

  localparam int VEC_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/encoder_8to3_seq_if.sv
// rtl/encoder_8to3_seq_if.sv - request/response bus of the sequential 8-to-3 encoder
//
// Purpose : bundles the request (in_*) and response (out_*) handshakes.
// Ports   : in_vec/in_valid/in_ready  - request vector handshake
//           out_code/out_valid/out_ready/out_last/out_zero - response beats
// Modports: slave  - the encoder (accepts vectors, emits codes)
//           master - the producer/consumer driving the encoder
interface encoder_8to3_seq_if;
  import encoder_pkg::*;

  logic [VEC_W-1:0]  in_vec;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              out_zero;

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_code, out_valid, out_last, out_zero
  );

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_code, out_valid, out_last, out_zero
  );

endinterface

// File: rtl/encoder_8to3_seq_pri_enc8.sv
// rtl/encoder_8to3_seq_pri_enc8.sv - combinational 8-bit priority encoder
//
// Purpose : index of the first set bit of an 8-bit vector, plus any-set and
//           exactly-one-set flags. Scan order: lowest bit first by default,
//           highest bit first when ENC_MSB_FIRST_EN is defined.
// Ports   : vec_i    - vector to scan
//           idx_o    - index of the selected set bit (0 when none set)
//           any_o    - at least one bit set
//           single_o - exactly one bit set
module pri_enc8
  import encoder_pkg::*;
(
  input  logic [VEC_W-1:0]  vec_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o,
  output logic              single_o
);

  // The loop runs towards the winning end so the last match overrides.
  always_comb begin
    idx_o = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < VEC_W; i++) begin
      if (vec_i[i]) idx_o = CODE_W'(i);
    end
`else
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = CODE_W'(i);
    end
`endif
  end

  assign any_o = |vec_i;

  // Clearing the lowest set bit leaves zero only for a one-hot vector.
  assign single_o = any_o && ((vec_i & (vec_i - VEC_W'(1))) == '0);

endmodule

// File: rtl/encoder_8to3_seq.sv
// rtl/encoder_8to3_seq.sv - sequential 8-to-3 encoder emitting one code per set bit
//
// Purpose : captures an 8-bit request vector, then emits the index of each
//           set bit as a separate beat (one beat flagged out_zero for an
//           all-zero vector). ENC_MSB_FIRST_EN selects highest-bit-first order.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - encoder_8to3_seq_if.slave request/response handshakes
module encoder_8to3_seq
  import encoder_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  encoder_8to3_seq_if.slave        bus
);

  state_e            state_q, state_d;
  logic [VEC_W-1:0]  pending_q, pending_d;

  logic [CODE_W-1:0] sel_idx;
  logic              any_set;
  logic              single_set;
  logic              emit;
  logic              last_beat;

  pri_enc8 u_pri_enc8 (
    .vec_i    (pending_q),
    .idx_o    (sel_idx),
    .any_o    (any_set),
    .single_o (single_set)
  );

  // Every output is a function of state_q/pending_q only.
  assign emit          = (state_q == EMIT);
  assign last_beat     = emit && (single_set || !any_set);
  assign bus.in_ready  = !emit;
  assign bus.out_valid = emit;
  assign bus.out_code  = emit ? sel_idx : '0;
  assign bus.out_last  = last_beat;
  assign bus.out_zero  = emit && !any_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pending_d = bus.in_vec;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        // in_valid is deliberately ignored here; the producer holds it.
        if (bus.out_ready) begin
          pending_d = pending_q & ~(VEC_W'(1) << sel_idx);
          if (last_beat) state_d = IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// tb/tb_encoder_8to3_seq.sv - self-checking bench for encoder_8to3_seq
module tb_encoder_8to3_seq;

  logic clk;
  logic rst_n;

  encoder_8to3_seq_if bus_if ();

  encoder_8to3_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Observed beats, packed 5 bits each as {zero, last, code}.
  logic [63:0] got_sig;
  int          got_n;
  int          hold_err;
  logic        first_valid;
  logic        ready_after;
  int          cycles;

  // Reference beats from the model, same packing.
  logic [63:0] exp_sig;
  int          exp_n;

  // Model: one beat per set bit in scan order, or a single zero beat.
  task automatic build_expected(input logic [7:0] v);
    int order[$];
    order.delete();
    exp_sig = '0;
    if (v == 8'h00) begin
      exp_sig[4:0] = {1'b1, 1'b1, 3'd0};
      exp_n = 1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
`ifdef ENC_MSB_FIRST_EN
          order.push_front(i);
`else
          order.push_back(i);
`endif
        end
      end
      exp_n = order.size();
      for (int k = 0; k < exp_n; k++) begin
        exp_sig[k*5 +: 5] = {1'b0, (k == exp_n - 1), 3'(order[k])};
      end
    end
  endtask

  // Driver/monitor: offers v, then consumes beats with out_ready chosen by
  // mode (0 always, 1 toggle starting high, 2 random). Records only.
  task automatic send_collect(input logic [7:0] v, input int mode,
                              input logic busy_valid, input logic [7:0] busy_vec);
    int   guard;
    logic tog;
    logic stalled;
    logic r;
    logic done;
    logic [4:0] held;
    got_sig = '0; got_n = 0; hold_err = 0;
    guard = 0;
    while (!bus_if.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus_if.in_vec    = v;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    bus_if.in_valid = busy_valid;
    bus_if.in_vec   = busy_vec;
    first_valid = bus_if.out_valid;
    cycles = 1; tog = 1'b1; stalled = 1'b0; done = 1'b0; held = '0;
    while (!done && cycles < 60) begin
      if (bus_if.out_valid) begin
        if (stalled && ({bus_if.out_zero, bus_if.out_last, bus_if.out_code} !== held))
          hold_err++;
        case (mode)
          0:       r = 1'b1;
          1:       r = tog;
          default: r = 1'($urandom_range(0, 1));
        endcase
        tog = ~tog;
        bus_if.out_ready = r;
        if (r) begin
          if (got_n < 12) got_sig[got_n*5 +: 5] = {bus_if.out_zero, bus_if.out_last, bus_if.out_code};
          got_n++;
          if (bus_if.out_last) done = 1'b1;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = {bus_if.out_zero, bus_if.out_last, bus_if.out_code};
        end
      end else begin
        bus_if.out_ready = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    ready_after      = bus_if.in_ready;
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.in_vec = 8'h00; bus_if.in_valid = 1'b0; bus_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus_if.out_valid); end
    n_cmp++; if (bus_if.out_code !== 3'd0) begin n_bad++; $display("FAIL reset_out_code got %0d want 0", bus_if.out_code); end
    n_cmp++; if (bus_if.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got %b want 0", bus_if.out_last); end
    n_cmp++; if (bus_if.out_zero !== 1'b0) begin n_bad++; $display("FAIL reset_out_zero got %b want 0", bus_if.out_zero); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus_if.in_ready); end
  endtask

  task automatic test_pattern();
    build_expected(8'b0010_0100);
    send_collect(8'b0010_0100, 0, 1'b0, 8'h00);
    n_cmp++; if (first_valid !== 1'b1) begin n_bad++; $display("FAIL pattern_latency out_valid got %b want 1", first_valid); end
    n_cmp++; if (got_n !== 2) begin n_bad++; $display("FAIL pattern_beats got %0d want 2", got_n); end
`ifdef ENC_MSB_FIRST_EN
    n_cmp++; if (got_sig[2:0] !== 3'd5) begin n_bad++; $display("FAIL pattern_first_code got %0d want 5", got_sig[2:0]); end
`else
    n_cmp++; if (got_sig[2:0] !== 3'd2) begin n_bad++; $display("FAIL pattern_first_code got %0d want 2", got_sig[2:0]); end
`endif
    n_cmp++; if (got_sig !== exp_sig) begin n_bad++; $display("FAIL pattern_beats_sig got %h want %h", got_sig, exp_sig); end
    n_cmp++; if (cycles !== 3) begin n_bad++; $display("FAIL pattern_turnaround got %0d want 3", cycles); end
    n_cmp++; if (ready_after !== 1'b1) begin n_bad++; $display("FAIL pattern_idle in_ready got %b want 1", ready_after); end
  endtask

  task automatic test_zero();
    build_expected(8'h00);
    send_collect(8'h00, 0, 1'b0, 8'h00);
    n_cmp++; if (got_n !== 1) begin n_bad++; $display("FAIL zero_beats got %0d want 1", got_n); end
    n_cmp++; if (got_sig !== exp_sig) begin n_bad++; $display("FAIL zero_sig got %h want %h", got_sig, exp_sig); end
    n_cmp++; if (ready_after !== 1'b1) begin n_bad++; $display("FAIL zero_idle in_ready got %b want 1", ready_after); end
    n_cmp++; if (bus_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL zero_idle out_valid got %b want 0", bus_if.out_valid); end
  endtask

  task automatic test_backpressure();
    build_expected(8'hFF);
    send_collect(8'hFF, 1, 1'b0, 8'h00);
    n_cmp++; if (got_n !== 8) begin n_bad++; $display("FAIL bp_beats got %0d want 8", got_n); end
    n_cmp++; if (got_sig !== exp_sig) begin n_bad++; $display("FAIL bp_sig got %h want %h", got_sig, exp_sig); end
    n_cmp++; if (hold_err !== 0) begin n_bad++; $display("FAIL bp_hold_stable got %0d changes want 0", hold_err); end
    n_cmp++; if (ready_after !== 1'b1) begin n_bad++; $display("FAIL bp_idle in_ready got %b want 1", ready_after); end
  endtask

  task automatic test_ignore_busy();
    build_expected(8'h81);
    send_collect(8'h81, 0, 1'b1, 8'h10);
    n_cmp++; if (got_n !== 2) begin n_bad++; $display("FAIL busy_beats got %0d want 2", got_n); end
    n_cmp++; if (got_sig !== exp_sig) begin n_bad++; $display("FAIL busy_sig got %h want %h", got_sig, exp_sig); end
    build_expected(8'h10);
    send_collect(8'h10, 0, 1'b0, 8'h00);
    n_cmp++; if (got_n !== 1) begin n_bad++; $display("FAIL busy_second_beats got %0d want 1", got_n); end
    n_cmp++; if (got_sig[2:0] !== 3'd4) begin n_bad++; $display("FAIL busy_second_code got %0d want 4", got_sig[2:0]); end
    n_cmp++; if (got_sig !== exp_sig) begin n_bad++; $display("FAIL busy_second_sig got %h want %h", got_sig, exp_sig); end
  endtask

  task automatic test_reset_mid();
    int extra;
    bus_if.in_vec = 8'h0F; bus_if.in_valid = 1'b1; bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_second_beat out_valid got %b want 1", bus_if.out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus_if.out_valid, bus_if.out_code, bus_if.out_last, bus_if.out_zero} !== 6'b0)
      begin n_bad++; $display("FAIL rstmid_outputs got %b want 000000", {bus_if.out_valid, bus_if.out_code, bus_if.out_last, bus_if.out_zero}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready got %b want 1", bus_if.in_ready); end
    extra = 0;
    repeat (10) begin
      if (bus_if.out_valid) extra++;
      @(negedge clk);
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL rstmid_no_more_beats got %0d want 0", extra); end
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 256; v++) begin
      build_expected(8'(v));
      send_collect(8'(v), 0, 1'b0, 8'h00);
      n_cmp++; if (got_n !== exp_n || got_sig !== exp_sig)
        begin n_bad++; $display("FAIL sweep_%02h got %0d beats %h want %0d beats %h", v, got_n, got_sig, exp_n, exp_sig); end
      n_cmp++; if (cycles !== exp_n + 1 || ready_after !== 1'b1)
        begin n_bad++; $display("FAIL sweep_turnaround_%02h got %0d cycles ready %b want %0d ready 1", v, cycles, ready_after, exp_n + 1); end
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int t = 0; t < 60; t++) begin
      v = 8'($urandom);
      build_expected(v);
      send_collect(v, 2, 1'($urandom_range(0, 1)), 8'($urandom));
      n_cmp++; if (got_n !== exp_n || got_sig !== exp_sig)
        begin n_bad++; $display("FAIL random_%02h got %0d beats %h want %0d beats %h", v, got_n, got_sig, exp_n, exp_sig); end
      n_cmp++; if (hold_err !== 0 || ready_after !== 1'b1 || cycles < exp_n + 1)
        begin n_bad++; $display("FAIL random_hs_%02h got hold %0d ready %b cycles %0d want 0 1 >=%0d", v, hold_err, ready_after, cycles, exp_n + 1); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_pattern();
    test_zero();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
